// File: rtl/param_universal_register_pkg.sv
// ureg_pkg: operation codes shared by the universal register and its users
package ureg_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;
endpackage

// File: rtl/param_universal_register_if.sv
// param_universal_register_if: control, data and status bundle of the universal register
interface param_universal_register_if #(parameter int WIDTH = 4);
  logic             preset;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             sout_l;
  logic             sout_r;
  logic             co;
  modport master (output preset, en, mode, d, sin_r, sin_l, input q, q_bar, sout_l, sout_r, co);
  modport slave (input preset, en, mode, d, sin_r, sin_l, output q, q_bar, sout_l, sout_r, co);
endinterface

// File: rtl/param_universal_register_dff.sv
// d_flip_flop_en_module: one bit with async active-low reset, sync preset and enable
module d_flip_flop_en_module #(parameter logic RV = 1'b0) (
  input  logic clk,
  input  logic rst,
  input  logic preset,
  input  logic en,
  input  logic d,
  output logic q,
  output logic q_bar
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RV;
    else if (preset) q <= 1'b1;
    else if (en) q <= d;
  assign q_bar = ~q;
endmodule

// File: rtl/param_universal_register.sv
// param_universal_register: WIDTH-bit hold/load/shift/rotate/count register with carry flag
module param_universal_register
  import ureg_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input logic clk,
  input logic rst,
  param_universal_register_if.slave bus
);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  logic [WIDTH-1:0] q, q_bar, next_q;
  logic next_co, co, unused_co_bar;
  always_comb begin
    next_q  = q;
    next_co = 1'b0;
    case (bus.mode)
      MODE_LOAD: next_q = bus.d;
      MODE_SHL: begin
        next_q  = {q[WIDTH-2:0], bus.sin_r};
        next_co = q[WIDTH-1];
      end
      MODE_SHR: begin
        next_q  = {bus.sin_l, q[WIDTH-1:1]};
        next_co = q[0];
      end
      MODE_ROTL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: next_q = {q[0], q[WIDTH-1:1]};
      MODE_INC:  {next_co, next_q} = {1'b0, q} + ONE;
      MODE_DEC:  {next_co, next_q} = {1'b0, q} - ONE;
      default:   next_q = q;
    endcase
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_flip_flop_en_module #(.RV(RESET_VALUE[i])) u_bit (
      .clk(clk), .rst(rst), .preset(bus.preset), .en(bus.en),
      .d(next_q[i]), .q(q[i]), .q_bar(q_bar[i])
    );
  end
  // preset must clear the flag rather than set it, so it is folded into d/en
  d_flip_flop_en_module #(.RV(1'b0)) u_co (
    .clk(clk), .rst(rst), .preset(1'b0), .en(bus.en | bus.preset),
    .d(~bus.preset & next_co), .q(co), .q_bar(unused_co_bar)
  );
  assign bus.q      = q;
  assign bus.q_bar  = q_bar;
  assign bus.sout_l = q[WIDTH-1];
  assign bus.sout_r = q[0];
  assign bus.co     = co;
endmodule

// File: tb/tb_param_universal_register.sv
// tb_param_universal_register: directed scoreboard bench for the 4-bit universal register
module tb_param_universal_register;
  import ureg_pkg::*;
  typedef struct {
    logic [3:0] q;
    logic       co;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int fails = 0;
  exp_t sb[$];
  param_universal_register_if #(.WIDTH(4)) bus ();
  param_universal_register #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input string tag, input logic e, input logic p, input logic [2:0] m,
                    input logic [3:0] dd, input logic sl, input logic sr,
                    input logic [3:0] eq, input logic eco);
    exp_t x;
    @(negedge clk);
    bus.en = e; bus.preset = p; bus.mode = m; bus.d = dd; bus.sin_l = sl; bus.sin_r = sr;
    sb.push_back('{eq, eco});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".q"}, bus.q, x.q);
    chk({tag, ".co"}, {3'b0, bus.co}, {3'b0, x.co});
    chk({tag, ".q_bar"}, bus.q_bar, ~x.q);
    chk({tag, ".sout_l"}, {3'b0, bus.sout_l}, {3'b0, x.q[3]});
    chk({tag, ".sout_r"}, {3'b0, bus.sout_r}, {3'b0, x.q[0]});
  endtask
  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.preset = 1'b0; bus.mode = MODE_HOLD; bus.d = 4'h0;
    bus.sin_l = 1'b0; bus.sin_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por.q", bus.q, 4'h0);
    chk("por.q_bar", bus.q_bar, 4'hF);
    chk("por.co", {3'b0, bus.co}, 4'h0);
    @(negedge clk) rst = 1'b1;
    op("load_a", 1, 0, MODE_LOAD, 4'hA, 0, 0, 4'hA, 0);
    op("shl_a",  1, 0, MODE_SHL,  4'h0, 0, 0, 4'h4, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.q", bus.q, 4'h0);
    chk("async_rst.q_bar", bus.q_bar, 4'hF);
    chk("async_rst.co", {3'b0, bus.co}, 4'h0);
    @(negedge clk) rst = 1'b1;
    op("rel0", 0, 0, MODE_LOAD, 4'h7, 1, 1, 4'h0, 0);
    op("rel1", 0, 0, MODE_INC,  4'h7, 1, 1, 4'h0, 0);
    op("rel2", 0, 0, MODE_DEC,  4'h7, 1, 1, 4'h0, 0);
    op("load_b", 1, 0, MODE_LOAD, 4'b1011, 0, 0, 4'b1011, 0);
    op("shl",    1, 0, MODE_SHL,  4'h0, 0, 0, 4'b0110, 1);
    op("shr",    1, 0, MODE_SHR,  4'h0, 1, 0, 4'b1011, 0);
    op("load_9", 1, 0, MODE_LOAD, 4'b1001, 0, 0, 4'b1001, 0);
    op("rotl",   1, 0, MODE_ROTL, 4'h0, 0, 0, 4'b0011, 0);
    op("rotr1",  1, 0, MODE_ROTR, 4'h0, 0, 0, 4'b1001, 0);
    op("rotr2",  1, 0, MODE_ROTR, 4'h0, 0, 0, 4'b1100, 0);
    op("load_e", 1, 0, MODE_LOAD, 4'hE, 0, 0, 4'hE, 0);
    op("inc1",   1, 0, MODE_INC,  4'h0, 0, 0, 4'hF, 0);
    op("inc2",   1, 0, MODE_INC,  4'h0, 0, 0, 4'h0, 1);
    op("co_hold", 0, 0, MODE_LOAD, 4'h9, 0, 0, 4'h0, 1);
    op("hold",   1, 0, MODE_HOLD, 4'h9, 0, 0, 4'h0, 0);
    op("dec1",   1, 0, MODE_DEC,  4'h0, 0, 0, 4'hF, 1);
    op("dec2",   1, 0, MODE_DEC,  4'h0, 0, 0, 4'hE, 0);
    op("load_3", 1, 0, MODE_LOAD, 4'h3, 0, 0, 4'h3, 0);
    op("preset_en", 1, 1, MODE_INC, 4'h0, 0, 0, 4'hF, 0);
    op("en_off", 0, 0, MODE_LOAD, 4'h5, 0, 0, 4'hF, 0);
    op("load_0", 1, 0, MODE_LOAD, 4'h0, 0, 0, 4'h0, 0);
    op("preset_noen", 0, 1, MODE_LOAD, 4'h5, 0, 0, 4'hF, 0);
    op("inc_wrap", 1, 0, MODE_INC, 4'h0, 0, 0, 4'h0, 1);
    op("preset_clr", 0, 1, MODE_HOLD, 4'h0, 0, 0, 4'hF, 0);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_inc.q", bus.q, 4'h0);
    chk("rst_mid_inc.co", {3'b0, bus.co}, 4'h0);
    chk("sb_empty", 4'(sb.size()), 4'h0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/param_universal_register.md
Name: param_universal_register

Overview:
- Parametrised successor to the team's fixed 4-bit D flip-flop register.
- Provides WIDTH-bit storage with asynchronous active-low reset and synchronous preset.
- Adds clock enable and eight operating modes: hold, parallel load, shift, rotate, increment and decrement.
- Serves as the general-purpose state/shift/count register for datapath and control blocks in the term project.

Parameters:
- WIDTH, 4, register width in bits; legal range >= 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on asynchronous reset.

Ports:
- clk  input  1  rising-edge clock; the block has one clock domain.
- rst  input  1  asynchronous, active-low reset.
- preset  input  1  synchronous, active-high; forces q to all-ones.
- en  input  1  clock enable for mode operations.
- mode  input  3  operation select (codes under Behaviour).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input, shifted into bit 0 on SHL.
- sin_l  input  1  serial input, shifted into bit WIDTH-1 on SHR.
- q  output  WIDTH  registered value.
- q_bar  output  WIDTH  bitwise inverse of q, always ~q.
- sout_l  output  1  q[WIDTH-1], combinational from the register.
- sout_r  output  1  q[0], combinational from the register.
- co  output  1  registered carry/borrow flag.

Behaviour:
- Clock and reset
  - Single clock, clk. Reset rst is asynchronous and active-low.
  - rst=0 immediately forces q=RESET_VALUE and co=0, independent of clk. Consequently q_bar=~RESET_VALUE, sout_l=RESET_VALUE[WIDTH-1] and sout_r=RESET_VALUE[0].
  - Release of reset takes effect at the first rising clk edge with rst=1. No glitch on q during release.
- Priority at each rising edge, highest first: rst, then preset, then en, then mode.
  - preset=1 (not gated by en): q <= all-ones, co <= 0.
  - en=0 and preset=0: q and co hold.
  - en=1 and preset=0: q is updated per mode, with a latency of one clock.
- Mode codes
  - 3'b000 HOLD: q <= q; co <= 0.
  - 3'b001 LOAD: q <= d; co <= 0.
  - 3'b010 SHL: q <= {q[WIDTH-2:0], sin_r}; co <= q[WIDTH-1] (the bit shifted out).
  - 3'b011 SHR: q <= {sin_l, q[WIDTH-1:1]}; co <= q[0].
  - 3'b100 ROTL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; co <= 0.
  - 3'b101 ROTR: q <= {q[0], q[WIDTH-1:1]}; co <= 0.
  - 3'b110 INC: q <= q+1 modulo 2^WIDTH; co <= 1 only when q was all-ones (wrap to 0), else 0.
  - 3'b111 DEC: q <= q-1 modulo 2^WIDTH; co <= 1 only when q was 0 (wrap to all-ones), else 0.
- Arithmetic: unsigned, WIDTH bits. The carry is computed with a WIDTH+1 internal sum; no other width extension is visible at the ports.
- co is valid for exactly the cycle following the operation that produced it. The next enabled non-shift/non-wrap operation clears it.
- Boundary conditions
  - Reset asserted during INC/DEC: q=RESET_VALUE immediately; the wrap is lost and co=0.
  - preset and en=1 together: preset wins; mode is ignored for that edge.
  - X on mode while en=1: no requirement beyond simulation X-propagation; the bench does not drive it.

Decomposition:
- Shared package ureg_pkg:
  - 3-bit mode localparams MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR, MODE_INC, MODE_DEC.
- Top level computes next_q and next_co combinationally with a case on mode.
- One natural sub-module: d_flip_flop_en_module.
  - Single-bit D flop with asynchronous active-low rst, synchronous preset and enable, providing q/q_bar.
  - Instantiated WIDTH times via generate; co uses its own instance.

Test Plan (WIDTH=4, RESET_VALUE=0):
- Reset: drive rst=0 mid-cycle after loading 4'hA -> q=0, q_bar=4'hF, co=0 immediately without a clock edge; hold 3 edges after release with en=0 -> q stays 0.
- Load and shifts:
  - LOAD d=4'b1011 -> q=4'b1011 one edge later.
  - SHL with sin_r=0 -> q=4'b0110, co=1.
  - SHR with sin_l=1 -> q=4'b1011, co=0.
- Rotates: q=4'b1001; ROTL -> 4'b0011; ROTR twice -> 4'b1001 then 4'b1100; co=0 throughout.
- Increment wrap:
  - q=4'hE; INC -> q=4'hF, co=0; INC -> q=4'h0, co=1.
  - HOLD -> q=4'h0, co=0.
- Decrement wrap: q=0; DEC -> q=4'hF, co=1; DEC -> q=4'hE, co=0.
- Priority:
  - en=1, mode=INC, preset=1 at q=4'h3 -> q=4'hF, co=0.
  - en=0, preset=0, mode=LOAD, d=4'h5 -> q unchanged.
